// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-hot column drive, frame-level debounce,
// single-cycle key event plus held / multi-key status levels.
module keypad_scan #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk0,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       multi
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, PRESSED, MULTI_ST} state_t;
   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

   state_t        state, state_n;
   res_t          res, prev_res;
   logic [3:0]    row_s1, row_s2;
   logic [DW-1:0] div;
   logic [1:0]    col_idx;
   logic [1:0]    acc_cnt, cnt_n;
   logic [3:0]    acc_code, code_n;
   logic [3:0]    prev_code;
   logic [3:0]    dbc, dbc_n;
   logic [2:0]    pop, sum;
   logic [1:0]    ridx;
   logic          slot_end, frame_end, same, stable;
   logic [3:0]    key_code_n;
   logic          key_valid_n, key_held_n, multi_n;

   assign col = 4'b0001 << col_idx;

   always_comb begin
      slot_end  = (div == DW'(SCAN_DIV - 1));
      frame_end = slot_end && (col_idx == 2'd3);
      pop = 3'(row_s2[0]) + 3'(row_s2[1]) + 3'(row_s2[2]) + 3'(row_s2[3]);
      sum = {1'b0, acc_cnt} + pop;
      cnt_n = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      ridx = 2'd0;
      case (row_s2)
         4'b0010: ridx = 2'd1;
         4'b0100: ridx = 2'd2;
         4'b1000: ridx = 2'd3;
         default: ridx = 2'd0;
      endcase
      code_n = (pop == 3'd1) ? {col_idx, ridx} : acc_code;
      case (cnt_n)
         2'd0:    res = RES_NONE;
         2'd1:    res = RES_SINGLE;
         default: res = RES_MULTI;
      endcase
      // code only distinguishes results when the frame saw a single key
      same   = (res == prev_res) && ((res != RES_SINGLE) || (code_n == prev_code));
      dbc_n  = same ? ((dbc < 4'(DEBOUNCE_SCANS)) ? dbc + 4'd1 : dbc) : 4'd1;
      stable = frame_end && same && (dbc == 4'(DEBOUNCE_SCANS - 1));
   end

   always_comb begin
      state_n     = state;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
      multi_n     = multi;
      if (stable) begin
         case (res)
            RES_NONE: begin
               state_n    = IDLE;
               key_held_n = 1'b0;
               multi_n    = 1'b0;
            end
            RES_SINGLE: begin
               if (state != PRESSED || code_n != key_code) begin
                  state_n     = PRESSED;
                  key_code_n  = code_n;
                  key_valid_n = 1'b1;
                  key_held_n  = 1'b1;
                  multi_n     = 1'b0;
               end
            end
            default: begin
               state_n    = MULTI_ST;
               key_held_n = 1'b0;
               multi_n    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk0) begin
      if (rst) begin
         row_s1    <= '0;
         row_s2    <= '0;
         div       <= '0;
         col_idx   <= '0;
         acc_cnt   <= '0;
         acc_code  <= '0;
         prev_res  <= RES_NONE;
         prev_code <= '0;
         dbc       <= '0;
         state     <= IDLE;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi     <= 1'b0;
      end else begin
         row_s1    <= row;
         row_s2    <= row_s1;
         state     <= state_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
         multi     <= multi_n;
         if (slot_end) begin
            div     <= '0;
            col_idx <= col_idx + 2'd1;
            if (frame_end) begin
               acc_cnt   <= '0;
               acc_code  <= '0;
               prev_res  <= res;
               prev_code <= code_n;
               dbc       <= dbc_n;
            end else begin
               acc_cnt  <= cnt_n;
               acc_code <= code_n;
            end
         end else begin
            div <= div + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives row from col; expected
// outputs come from a frame-level model of the debounce and key-event rules.
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam int NONE_R  = -1;
   localparam int MULTI_R = -2;

   logic       clk0 = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid, key_held, multi;
   logic [15:0] mask = '0;

   int checks   = 0;
   int failures = 0;

   int hist[$];
   int exp_code  = 0;
   int exp_valid = 0;
   int exp_held  = 0;
   int exp_multi = 0;
   int exp_pressed = 0;

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
      .clk0(clk0), .rst(rst), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid),
      .key_held(key_held), .multi(multi)
   );

   always #5 clk0 = ~clk0;

   // Pressed key at (c,r) is mask bit c*4+r; it shorts column c to row r.
   always_comb begin
      row = '0;
      for (int c = 0; c < 4; c++)
         if (col[c]) row = row | mask[c*4 +: 4];
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_frame(input logic [15:0] m);
      int r, run;
      if ($countones(m) == 0)      r = NONE_R;
      else if ($countones(m) >= 2) r = MULTI_R;
      else begin
         r = 0;
         for (int i = 0; i < 16; i++) if (m[i]) r = i;
      end
      hist.push_back(r);
      run = 0;
      for (int k = hist.size() - 1; k >= 0 && hist[k] == r; k--) run++;
      exp_valid = 0;
      if (run == DB) begin
         if (r == NONE_R) begin
            exp_pressed = 0; exp_held = 0; exp_multi = 0;
         end else if (r == MULTI_R) begin
            exp_pressed = 0; exp_held = 0; exp_multi = 1;
         end else if (!exp_pressed || r != exp_code) begin
            exp_pressed = 1; exp_code = r; exp_valid = 1;
            exp_held = 1; exp_multi = 0;
         end
      end
   endtask

   task automatic check_outputs(input int i);
      check("col", col, 1 << ((i / SD) % 4));
      check("key_valid", key_valid, exp_valid);
      check("key_held", key_held, exp_held);
      check("multi", multi, exp_multi);
      check("key_code", key_code, exp_code);
   endtask

   task automatic run_cycles(input logic [15:0] m, input int n);
      mask = m;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk0);
         if (i == 4 * SD) model_frame(m);
         else exp_valid = 0;
         @(negedge clk0);
         check_outputs(i);
      end
   endtask

   task automatic frames(input logic [15:0] m, input int n);
      for (int f = 0; f < n; f++) run_cycles(m, 4 * SD);
   endtask

   task automatic do_reset();
      @(negedge clk0);
      rst = 1'b1;
      @(posedge clk0);
      @(negedge clk0);
      rst = 1'b0;
      hist.delete();
      exp_code = 0; exp_valid = 0; exp_held = 0; exp_multi = 0; exp_pressed = 0;
      check("rst_col", col, 1);
      check("rst_valid", key_valid, 0);
      check("rst_held", key_held, 0);
      check("rst_multi", multi, 0);
      check("rst_code", key_code, 0);
   endtask

   initial begin
      logic [15:0] m;
      repeat (3) @(posedge clk0);
      do_reset();
      frames('0, 10);

      do_reset();
      frames(16'h0400, 5);                 // key {2,2}
      frames('0, 4);

      for (int f = 0; f < 12; f++)
         frames((f % 2) ? 16'h0002 : 16'h0000, 1);
      frames('0, 3);

      frames(16'h0008, 4);                 // {0,3}
      frames(16'h1008, 4);                 // add {3,0}
      frames(16'h0008, 4);
      frames('0, 4);

      frames(16'h0010, 4);                 // {1,0} then {1,1}
      frames(16'h0020, 4);
      frames('0, 4);

      frames(16'h0040, 4);
      run_cycles(16'h0040, 7);
      do_reset();
      frames(16'h0040, 4);
      frames('0, 4);

      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 2))
            0: m = '0;
            1: m = 16'd1 << $urandom_range(0, 15);
            default: m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
         endcase
         frames(m, $urandom_range(1, 5));
      end
      frames('0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
